// File: rtl/accel_mem_master.sv
// accel_mem_master: reads a 64-byte block from an ACB slot, hands it to the
// hash engine, then writes the 32-byte digest back as eight 4-byte beats.
// Build option: ACCEL_MEM_BSWAP_EN byte-reverses each digest word before write.
module accel_mem_master #(
  parameter int unsigned MEM_SIZE   = 65536,
  parameter int unsigned RES_OFFSET = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  base_addr,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  accel_addr,
  output logic [31:0]  accel_wrt_data,
  output logic         accel_wrt_en,
  output logic         accel_rd_en,
  input  logic [511:0] accel_rd_data,
  input  logic         mem_err,
  input  logic         cpu_wrt_act,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  input  logic         hash_valid,
  output logic         hash_ready,
  input  logic [255:0] hash_data
);

  localparam logic [16:0] ADDR_LIMIT = 17'(MEM_SIZE - 64 - RES_OFFSET);
  localparam logic [15:0] RES_OFF16  = 16'(RES_OFFSET);

  typedef enum logic [2:0] {IDLE, READ, SEND, WAIT_HASH, WRITE, FIN} state_t;

  state_t         state_q, state_d;
  logic [15:0]    base_q, base_d;
  logic [511:0]   blk_q, blk_d;
  logic [255:0]   hash_q, hash_d;
  logic [2:0]     beat_q, beat_d;
  logic           err_q, err_d;
  logic [31:0]    word, wr_word;

  // State and datapath registers; reset aborts any operation without done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      blk_q   <= '0;
      hash_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      blk_q   <= blk_d;
      hash_q  <= hash_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Select the current digest word, optionally byte-reversed
  always_comb begin
    word = hash_q[{beat_q, 5'b0} +: 32];
`ifdef ACCEL_MEM_BSWAP_EN
    wr_word = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
    wr_word = word;
`endif
  end

  // Next-state logic and memory/engine handshake outputs
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    blk_d          = blk_q;
    hash_d         = hash_q;
    beat_d         = beat_q;
    err_d          = err_q;
    done           = 1'b0;
    accel_addr     = '0;
    accel_wrt_data = '0;
    accel_wrt_en   = 1'b0;
    accel_rd_en    = 1'b0;
    blk_valid      = 1'b0;
    hash_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr;
          err_d  = 1'b0;
          if ({1'b0, base_addr} > ADDR_LIMIT) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        accel_rd_en = 1'b1;
        accel_addr  = base_q;
        blk_d       = accel_rd_data;
        if (mem_err) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        blk_valid = 1'b1;
        if (blk_ready) state_d = WAIT_HASH;
      end
      WAIT_HASH: begin
        hash_ready = 1'b1;
        if (hash_valid) begin
          hash_d  = hash_data;
          beat_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Data stays on the bus through a CPU stall; the address only
        // appears while the strobe is high.
        accel_wrt_data = wr_word;
        accel_wrt_en   = !cpu_wrt_act;
        if (accel_wrt_en) begin
          accel_addr = base_q + RES_OFF16 + {11'b0, beat_q, 2'b00};
          if (mem_err) err_d = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign blk_data = blk_q;

endmodule

// File: tb/tb_accel_mem_master.sv
// Bench for accel_mem_master: byte-array memory model, behavioural hash
// engine (digest byte j = block byte j + 1) and a write-back scoreboard.
module tb_accel_mem_master;

  logic         clk = 1'b0;
  logic         rst_n, start, busy, done, err;
  logic [15:0]  base_addr, accel_addr;
  logic [31:0]  accel_wrt_data;
  logic         accel_wrt_en, accel_rd_en, mem_err, cpu_wrt_act;
  logic [511:0] accel_rd_data, blk_data;
  logic         blk_valid, blk_ready, hash_valid, hash_ready;
  logic [255:0] hash_data;

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  accel_mem_master #(.MEM_SIZE(65536), .RES_OFFSET(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err), .accel_addr(accel_addr),
    .accel_wrt_data(accel_wrt_data), .accel_wrt_en(accel_wrt_en),
    .accel_rd_en(accel_rd_en), .accel_rd_data(accel_rd_data),
    .mem_err(mem_err), .cpu_wrt_act(cpu_wrt_act), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .hash_valid(hash_valid),
    .hash_ready(hash_ready), .hash_data(hash_data)
  );

  // One operation, cycle by cycle from a negedge. Returns edges from the
  // start-sampling edge to the cycle showing done (-1 if reset aborted it).
  task automatic run_op(input logic [15:0] b, input int rdly, input int hdly,
                        input int stall_beat, input int stall_len,
                        input int merr_beat, input int rst_beat,
                        output int lat, output logic err_at_done,
                        output logic [511:0] blk_snap);
    bit oob, blk_hs, hash_hs, have_snap, stalled, finished;
    int vcnt, hcnt, scnt, nbeats;
    logic [15:0] a;
    logic [31:0] w;
    wr_t got, exp;
    oob = (b > 16'hFF80);
    blk_hs = 0; hash_hs = 0; have_snap = 0; finished = 0;
    vcnt = 0; hcnt = 0; scnt = 0; nbeats = 0;
    err_at_done = 1'b0; blk_snap = '0; lat = 0;
    if (!oob) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 4; j++) begin
          a = b + 16'(4 * i + j);
          w[8*j +: 8] = mem[a] + 8'd1;
        end
`ifdef ACCEL_MEM_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        exp_q.push_back('{addr: b + 16'd64 + 16'(4 * i), data: w});
      end
    end
    start = 1'b1; base_addr = b;
    @(negedge clk);
    for (int c = 1; c <= 200 && !finished; c++) begin
      lat = c;
      // start pulses while busy must be ignored
      start     = ($urandom_range(0, 2) == 0);
      base_addr = 16'($urandom);
      blk_ready  = blk_valid && (vcnt >= rdly);
      hash_valid = hash_ready && (hcnt >= hdly);
      for (int j = 0; j < 32; j++) hash_data[8*j +: 8] = blk_data[8*j +: 8] + 8'd1;
      hash_data[255:248] = hash_data[255:248];
      stalled     = hash_hs && (nbeats == stall_beat) && (scnt < stall_len);
      cpu_wrt_act = stalled;
      mem_err     = hash_hs && (nbeats == merr_beat) && !stalled;
      #1;
      accel_rd_data = '0;
      if (accel_rd_en)
        for (int i = 0; i < 64; i++) accel_rd_data[8*i +: 8] = mem[accel_addr + 16'(i)];
      checks++;
      if (accel_rd_en !== (c == 1 && !oob)) begin
        errors++; $display("FAIL rd_en cycle %0d: got %b", c, accel_rd_en);
      end
      checks++;
      if (accel_rd_en && accel_addr !== b) begin
        errors++; $display("FAIL rd_addr: got %h want %h", accel_addr, b);
      end
      checks++;
      if (accel_wrt_en && (accel_rd_en || !hash_hs)) begin
        errors++; $display("FAIL wrt_en_phase cycle %0d: wrt_en=%b rd_en=%b", c, accel_wrt_en, accel_rd_en);
      end
      checks++;
      if (!accel_rd_en && !accel_wrt_en && accel_addr !== 16'h0) begin
        errors++; $display("FAIL addr_idle: got %h want 0000", accel_addr);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy cycle %0d: got %b want 1", c, busy);
      end
      checks++;
      if (hash_ready !== (blk_hs && !hash_hs)) begin
        errors++; $display("FAIL hash_ready cycle %0d: got %b want %b", c, hash_ready, blk_hs && !hash_hs);
      end
      checks++;
      if (blk_valid !== (!oob && c >= 2 && !blk_hs)) begin
        errors++; $display("FAIL blk_valid cycle %0d: got %b", c, blk_valid);
      end
      if (stalled) begin
        checks++;
        if (accel_wrt_en !== 1'b0) begin
          errors++; $display("FAIL stall_wrt_en: got %b want 0", accel_wrt_en);
        end
      end
      if (blk_valid) begin
        if (!have_snap) begin
          blk_snap = blk_data; have_snap = 1;
        end else begin
          checks++;
          if (blk_data !== blk_snap) begin
            errors++; $display("FAIL blk_stable: got %h want %h", blk_data, blk_snap);
          end
        end
      end
      if (rst_beat >= 0 && hash_hs && nbeats == rst_beat) begin
        rst_n = 1'b0; start = 1'b0; mem_err = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err, accel_addr, accel_wrt_data, accel_wrt_en, accel_rd_en,
             blk_valid, hash_ready, blk_data} !== '0) begin
          errors++; $display("FAIL reset_outputs: busy=%b done=%b err=%b addr=%h wen=%b", busy, done, err, accel_addr, accel_wrt_en);
        end
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_done: done=%b busy=%b", done, busy);
          end
        end
        lat = -1;
        return;
      end
      if (accel_wrt_en) begin
        got = '{addr: accel_addr, data: accel_wrt_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL write_extra: got %h/%h want none", got.addr, got.data);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++; $display("FAIL write_beat%0d: got %h/%h want %h/%h", nbeats, got.addr, got.data, exp.addr, exp.data);
          end
        end
        for (int j = 0; j < 4; j++) mem[accel_addr + 16'(j)] = accel_wrt_data[8*j +: 8];
        nbeats++;
      end
      if (done) begin
        err_at_done = err; finished = 1;
      end else begin
        if (blk_valid) vcnt++;
        if (blk_valid && blk_ready) blk_hs = 1;
        if (hash_ready) hcnt++;
        if (hash_ready && hash_valid) hash_hs = 1;
        if (stalled) scnt++;
        @(negedge clk);
      end
    end
    checks++;
    if (!finished) begin
      errors++; $display("FAIL done_timeout: no done within 200 cycles");
      lat = 999;
    end
    start = 1'b0; blk_ready = 1'b0; hash_valid = 1'b0; cpu_wrt_act = 1'b0; mem_err = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b busy=%b want 0/0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL beats_missing: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; mem_err = 1'b0; cpu_wrt_act = 1'b0;
    blk_ready = 1'b0; hash_valid = 1'b0; hash_data = '0; accel_rd_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, accel_addr, accel_wrt_data, accel_wrt_en, accel_rd_en,
         blk_valid, hash_ready, blk_data} !== '0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b err=%b addr=%h", busy, done, err, accel_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic e; logic [511:0] s;
    logic [31:0] m;
    run_op(16'h5000, 0, 0, -1, 0, -1, -1, lat, e, s);
    checks++;
    if (lat != 12) begin errors++; $display("FAIL basic_latency: got %0d want 12", lat); end
    checks++;
    if (e !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b/%b want 0", e, err); end
    checks++;
    if (s[7:0] !== 8'h00 || s[511:504] !== 8'h3F) begin
      errors++; $display("FAIL basic_blk: got %h..%h want 00..3f", s[7:0], s[511:504]);
    end
    m = {mem[16'h5043], mem[16'h5042], mem[16'h5041], mem[16'h5040]};
    checks++;
`ifdef ACCEL_MEM_BSWAP_EN
    if (m !== 32'h01020304) begin errors++; $display("FAIL bswap_mem: got %h want 01020304", m); end
`else
    if (m !== 32'h04030201) begin errors++; $display("FAIL basic_mem: got %h want 04030201", m); end
`endif
  endtask

  task automatic test_stall();
    int lat; logic e; logic [511:0] s;
    run_op(16'h5000, 0, 0, 3, 5, -1, -1, lat, e, s);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL stall_latency: got %0d want 17", lat); end
  endtask

  task automatic test_bounds();
    int lat; logic e; logic [511:0] s;
    // mem_err on a completed write beat: err set, all beats still written
    run_op(16'h5000, 0, 0, -1, 0, 2, -1, lat, e, s);
    checks++;
    if (lat != 12 || e !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL wr_mem_err: got lat=%0d err=%b want 12/1", lat, e);
    end
    // out of range: done in the cycle right after the start cycle, no access
    run_op(16'hFF90, 0, 0, -1, 0, -1, -1, lat, e, s);
    checks++;
    if (lat != 1 || e !== 1'b1) begin errors++; $display("FAIL bounds_ff90: got lat=%0d err=%b want 1/1", lat, e); end
    run_op(16'hFF81, 0, 0, -1, 0, -1, -1, lat, e, s);
    checks++;
    if (lat != 1 || e !== 1'b1) begin errors++; $display("FAIL bounds_ff81: got lat=%0d err=%b want 1/1", lat, e); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    // highest legal base clears err
    run_op(16'hFF80, 0, 0, -1, 0, -1, -1, lat, e, s);
    checks++;
    if (lat != 12 || e !== 1'b0) begin errors++; $display("FAIL bounds_ff80: got lat=%0d err=%b want 12/0", lat, e); end
  endtask

  task automatic test_backpressure();
    int lat; logic e; logic [511:0] s;
    run_op(16'h1234, 10, 20, -1, 0, -1, -1, lat, e, s);
    checks++;
    if (lat != 42 || e !== 1'b0) begin errors++; $display("FAIL backpressure: got lat=%0d err=%b want 42/0", lat, e); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic e; logic [511:0] s;
    run_op(16'h2000, 0, 0, -1, 0, -1, 4, lat, e, s);
    checks++;
    if (lat != -1) begin errors++; $display("FAIL reset_abort: got lat=%0d want -1", lat); end
    run_op(16'h2000, 0, 0, -1, 0, -1, -1, lat, e, s);
    checks++;
    if (lat != 12 || e !== 1'b0) begin errors++; $display("FAIL after_reset: got lat=%0d err=%b want 12/0", lat, e); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A ^ 8'(i >> 8);
    for (int i = 0; i < 64; i++) mem[16'h5000 + 16'(i)] = 8'(i);
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_bounds();
    test_backpressure();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
